// File: rtl/frame_config_loader.sv
// -----------------------------------------------------------------------------
// frame_config_loader
//
// Deserialises a configuration bit stream into {address, data} frames and drives
// the shared latch-write bus of the I/O tile configuration memories. Each write
// is a setup / strobe / hold sequence, so the level-sensitive latches never see
// address or data move while enable is high.
//
// Parameters
//   ADDR_WIDTH    frame address width (also width of address output)
//   NUM_MEM       number of addressable latches, legal addresses 0..NUM_MEM-1
//   ENABLE_CYCLES enable strobe length in clocks (>= 1)
//   CNT_WIDTH     width of frame_count
//
// Ports
//   prog_clk     configuration clock, all state moves on its rising edge
//   pReset       asynchronous active-high reset
//   cfg_valid    cfg_bit is valid this cycle
//   cfg_bit      serial frame bit, address MSB first, data bit last
//   cfg_ready    loader accepts a bit this cycle
//   enable       latch write strobe
//   address      latch address (registered)
//   data_in      latch data (registered)
//   frame_done   one-cycle pulse while a frame's write sequence finishes
//   frame_count  frames completed incl. rejected ones, saturating
//   addr_err     sticky: some frame addressed a latch >= NUM_MEM
// -----------------------------------------------------------------------------
module frame_config_loader #(
    parameter int ADDR_WIDTH    = 4,
    parameter int NUM_MEM       = 16,
    parameter int ENABLE_CYCLES = 1,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  cfg_valid,
    input  logic                  cfg_bit,
    output logic                  cfg_ready,
    output logic                  enable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  data_in,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic                  addr_err
);

    localparam int FRAME_BITS = ADDR_WIDTH + 1;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam int STB_CNT_W  = (ENABLE_CYCLES > 1) ? $clog2(ENABLE_CYCLES) : 1;
    localparam int CMP_W      = ADDR_WIDTH + 1;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [STB_CNT_W-1:0] LAST_STB = STB_CNT_W'(ENABLE_CYCLES - 1);
    // One extra bit so NUM_MEM == 2**ADDR_WIDTH is representable.
    localparam logic [CMP_W-1:0]     NUM_MEM_L = CMP_W'(NUM_MEM);

    typedef enum logic [1:0] {
        ST_SHIFT,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    state_t                  state_reg, state_next;
    logic [BIT_CNT_W-1:0]    bit_cnt_reg;
    logic [ADDR_WIDTH-1:0]   shreg_reg;
    logic [STB_CNT_W-1:0]    stb_cnt_reg;
    logic                    cfg_ready_reg;
    logic                    enable_reg;
    logic                    frame_done_reg;
    logic [ADDR_WIDTH-1:0]   address_reg;
    logic                    data_in_reg;
    logic [CNT_WIDTH-1:0]    frame_count_reg;
    logic                    addr_err_reg;

    logic accept;
    logic last_bit;
    logic in_range;

    // cfg_ready_reg is high exactly in SHIFT, so it doubles as the accept gate.
    assign accept   = cfg_valid && cfg_ready_reg;
    assign last_bit = accept && (bit_cnt_reg == LAST_BIT);
    assign in_range = {1'b0, address_reg} < NUM_MEM_L;

    // State register
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_reg <= ST_SHIFT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_SHIFT:  if (last_bit) state_next = ST_SETUP;
            ST_SETUP:  state_next = in_range ? ST_STROBE : ST_HOLD;
            ST_STROBE: if (stb_cnt_reg == LAST_STB) state_next = ST_HOLD;
            ST_HOLD:   state_next = ST_SHIFT;
            default:   state_next = ST_SHIFT;
        endcase
    end

    // Datapath and registered outputs. Bus outputs are decoded from the next
    // state so they are flops, not decodes of the state register.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            bit_cnt_reg     <= '0;
            shreg_reg       <= '0;
            stb_cnt_reg     <= '0;
            cfg_ready_reg   <= 1'b1;
            enable_reg      <= 1'b0;
            frame_done_reg  <= 1'b0;
            address_reg     <= '0;
            data_in_reg     <= 1'b0;
            frame_count_reg <= '0;
            addr_err_reg    <= 1'b0;
        end else begin
            cfg_ready_reg  <= (state_next == ST_SHIFT);
            enable_reg     <= (state_next == ST_STROBE);
            frame_done_reg <= (state_next == ST_HOLD);

            if (accept) begin
                shreg_reg <= (shreg_reg << 1) | ADDR_WIDTH'(cfg_bit);
                if (last_bit) begin
                    // shreg already holds the full address; this bit is data.
                    bit_cnt_reg <= '0;
                    address_reg <= shreg_reg;
                    data_in_reg <= cfg_bit;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
            end

            if (state_reg == ST_STROBE && stb_cnt_reg != LAST_STB) begin
                stb_cnt_reg <= stb_cnt_reg + 1'b1;
            end else begin
                stb_cnt_reg <= '0;
            end

            if (state_reg == ST_SETUP && !in_range) begin
                addr_err_reg <= 1'b1;
            end

            if (state_reg == ST_HOLD && frame_count_reg != '1) begin
                frame_count_reg <= frame_count_reg + 1'b1;
            end
        end
    end

    assign cfg_ready   = cfg_ready_reg;
    assign enable      = enable_reg;
    assign address     = address_reg;
    assign data_in     = data_in_reg;
    assign frame_done  = frame_done_reg;
    assign frame_count = frame_count_reg;
    assign addr_err    = addr_err_reg;

endmodule

// File: tb/tb_frame_config_loader.sv
// -----------------------------------------------------------------------------
// tb_frame_config_loader
//
// Three loader instances share one clock and reset:
//   dut 0: defaults (ADDR_WIDTH 4, NUM_MEM 16, ENABLE_CYCLES 1, CNT_WIDTH 8)
//   dut 1: ENABLE_CYCLES 3
//   dut 2: NUM_MEM 10, ENABLE_CYCLES 3, CNT_WIDTH 2
// Directed cycle table on dut 0, hand-written sequences for the rest.
// -----------------------------------------------------------------------------
module tb_frame_config_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] vld  = '0;
    logic [2:0] bitv = '0;

    wire  [2:0] rdy_v, en_v, done_v, data_v, err_v;
    wire  [3:0] addr_v [3];
    wire  [7:0] cnt_v  [3];
    wire  [1:0] cnt_c;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    frame_config_loader #(.ADDR_WIDTH(4), .NUM_MEM(16), .ENABLE_CYCLES(1), .CNT_WIDTH(8)) dut_a (
        .prog_clk(clk), .pReset(rst), .cfg_valid(vld[0]), .cfg_bit(bitv[0]),
        .cfg_ready(rdy_v[0]), .enable(en_v[0]), .address(addr_v[0]), .data_in(data_v[0]),
        .frame_done(done_v[0]), .frame_count(cnt_v[0]), .addr_err(err_v[0]));

    frame_config_loader #(.ADDR_WIDTH(4), .NUM_MEM(16), .ENABLE_CYCLES(3), .CNT_WIDTH(8)) dut_b (
        .prog_clk(clk), .pReset(rst), .cfg_valid(vld[1]), .cfg_bit(bitv[1]),
        .cfg_ready(rdy_v[1]), .enable(en_v[1]), .address(addr_v[1]), .data_in(data_v[1]),
        .frame_done(done_v[1]), .frame_count(cnt_v[1]), .addr_err(err_v[1]));

    frame_config_loader #(.ADDR_WIDTH(4), .NUM_MEM(10), .ENABLE_CYCLES(3), .CNT_WIDTH(2)) dut_c (
        .prog_clk(clk), .pReset(rst), .cfg_valid(vld[2]), .cfg_bit(bitv[2]),
        .cfg_ready(rdy_v[2]), .enable(en_v[2]), .address(addr_v[2]), .data_in(data_v[2]),
        .frame_done(done_v[2]), .frame_count(cnt_c), .addr_err(err_v[2]));

    assign cnt_v[2] = {6'b0, cnt_c};

    typedef struct {
        bit v;
        bit b;
        bit rdy;
        bit en;
        bit done;
        int addr;
        bit data;
        int cnt;
        bit err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit v, bit b, bit rdy, bit en, bit done,
                                int addr, bit data, int cnt, bit err);
        vec_t r;
        r.v = v; r.b = b; r.rdy = rdy; r.en = en; r.done = done;
        r.addr = addr; r.data = data; r.cnt = cnt; r.err = err;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int d, input string tag);
        check($sformatf("%s_d%0d_ready", tag, d), int'(rdy_v[d]), 1);
        check($sformatf("%s_d%0d_enable", tag, d), int'(en_v[d]), 0);
        check($sformatf("%s_d%0d_done", tag, d), int'(done_v[d]), 0);
        check($sformatf("%s_d%0d_addr", tag, d), int'(addr_v[d]), 0);
        check($sformatf("%s_d%0d_data", tag, d), int'(data_v[d]), 0);
        check($sformatf("%s_d%0d_count", tag, d), int'(cnt_v[d]), 0);
        check($sformatf("%s_d%0d_err", tag, d), int'(err_v[d]), 0);
    endtask

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        while (!rdy_v[d] && n < 20) begin
            step();
            n++;
        end
        if (!rdy_v[d]) check($sformatf("ready_timeout_d%0d", d), 0, 1);
    endtask

    // Sends one frame; returns #1 after the edge that accepted the data bit.
    task automatic send_frame(input int d, input int a, input bit dat);
        logic [4:0] fr;
        fr = {a[3:0], dat};
        for (int i = 4; i >= 0; i--) begin
            wait_ready(d);
            vld[d]  = 1'b1;
            bitv[d] = fr[i];
            step();
        end
        vld[d]  = 1'b0;
        bitv[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Stimulus table for dut 0: inputs for the edge, expected outputs after it.
        // Frame 1: address 5, data 1, valid held high while busy.
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 5, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 5, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 5, 1, 1, 0));
        // Frame 2: address 10, data 0, with a valid gap mid-frame.
        tbl.push_back(mk(1, 1, 1, 0, 0, 5, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 5, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 5, 1, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 5, 1, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 5, 1, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 5, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 10, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 10, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 10, 0, 2, 0));
        // Frame 3: top legal address 15, data 1.
        tbl.push_back(mk(1, 1, 1, 0, 0, 10, 0, 2, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 10, 0, 2, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 10, 0, 2, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 10, 0, 2, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 15, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 15, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 15, 1, 2, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 15, 1, 3, 0));

        // ---------------- reset with random inputs ----------------
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vld  = 3'($urandom);
            bitv = 3'($urandom);
            step();
        end
        for (int d = 0; d < 3; d++) check_idle(d, "in_reset");
        rst  = 1'b0;
        vld  = '0;
        bitv = '0;
        #1;
        for (int d = 0; d < 3; d++) check_idle(d, "post_reset");

        // ---------------- table-driven single frames on dut 0 ----------------
        foreach (tbl[i]) begin
            vld[0]  = tbl[i].v;
            bitv[0] = tbl[i].b;
            step();
            check($sformatf("row%0d_ready", i), int'(rdy_v[0]), int'(tbl[i].rdy));
            check($sformatf("row%0d_enable", i), int'(en_v[0]), int'(tbl[i].en));
            check($sformatf("row%0d_done", i), int'(done_v[0]), int'(tbl[i].done));
            check($sformatf("row%0d_addr", i), int'(addr_v[0]), tbl[i].addr);
            check($sformatf("row%0d_data", i), int'(data_v[0]), int'(tbl[i].data));
            check($sformatf("row%0d_count", i), int'(cnt_v[0]), tbl[i].cnt);
            check($sformatf("row%0d_err", i), int'(err_v[0]), int'(tbl[i].err));
        end
        vld[0] = 1'b0;

        // ---------------- back-to-back frames on dut 1 (3-cycle strobe) ----------------
        begin
            logic [14:0] stream;
            int exp_addr [3];
            int exp_data [3];
            int idx, nstb, run, last_addr, last_data;
            bit en_prev, rdy_before;
            stream = 15'b00001_11110_01111;
            exp_addr[0] = 0;  exp_data[0] = 1;
            exp_addr[1] = 15; exp_data[1] = 0;
            exp_addr[2] = 7;  exp_data[2] = 1;
            idx = 0; nstb = 0; run = 0; en_prev = 1'b0;
            last_addr = 0; last_data = 0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                vld[1]     = (idx < 15);
                bitv[1]    = (idx < 15) ? stream[14 - idx] : 1'b0;
                rdy_before = rdy_v[1];
                step();
                if (rdy_before && vld[1]) idx++;
                if (en_v[1] && !en_prev) begin
                    run = 1;
                    if (nstb < 3) begin
                        check($sformatf("b2b_strobe%0d_addr", nstb), int'(addr_v[1]), exp_addr[nstb]);
                        check($sformatf("b2b_strobe%0d_data", nstb), int'(data_v[1]), exp_data[nstb]);
                    end
                    nstb++;
                end else if (en_v[1] && en_prev) begin
                    run++;
                    check("b2b_addr_stable", int'(addr_v[1]), last_addr);
                    check("b2b_data_stable", int'(data_v[1]), last_data);
                end else if (!en_v[1] && en_prev) begin
                    check("b2b_strobe_len", run, 3);
                end
                last_addr = int'(addr_v[1]);
                last_data = int'(data_v[1]);
                en_prev   = en_v[1];
            end
            vld[1] = 1'b0;
            check("b2b_bits_consumed", idx, 15);
            check("b2b_strobe_count", nstb, 3);
            check("b2b_frame_count", int'(cnt_v[1]), 3);
        end

        // ---------------- out-of-range address on dut 2 (NUM_MEM 10) ----------------
        send_frame(2, 12, 1'b1);                 // edge E
        check("oor_E_err", int'(err_v[2]), 0);
        check("oor_E_ready", int'(rdy_v[2]), 0);
        check("oor_E_addr", int'(addr_v[2]), 12);
        step();                                  // E+1: HOLD
        check("oor_E1_err", int'(err_v[2]), 1);
        check("oor_E1_enable", int'(en_v[2]), 0);
        check("oor_E1_done", int'(done_v[2]), 1);
        step();                                  // E+2: back in SHIFT
        check("oor_E2_ready", int'(rdy_v[2]), 1);
        check("oor_E2_done", int'(done_v[2]), 0);
        check("oor_E2_enable", int'(en_v[2]), 0);
        check("oor_E2_count", int'(cnt_v[2]), 1);
        // Legal frame afterwards still strobes; error stays set.
        send_frame(2, 3, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("legal_E%0d_enable", k), int'(en_v[2]), 1);
            check($sformatf("legal_E%0d_addr", k), int'(addr_v[2]), 3);
        end
        step();
        check("legal_E4_enable", int'(en_v[2]), 0);
        check("legal_E4_done", int'(done_v[2]), 1);
        step();
        check("legal_E5_ready", int'(rdy_v[2]), 1);
        check("legal_E5_count", int'(cnt_v[2]), 2);
        check("legal_E5_err_sticky", int'(err_v[2]), 1);

        // ---------------- reset during STROBE on dut 1 ----------------
        rst = 1'b1; step(); rst = 1'b0; step();
        send_frame(1, 9, 1'b1);
        step();
        check("mid_strobe_enable", int'(en_v[1]), 1);
        #3;
        rst = 1'b1;
        #1;                                      // no clock edge in between
        check("async_enable_drop", int'(en_v[1]), 0);
        check("async_ready", int'(rdy_v[1]), 1);
        check("async_addr", int'(addr_v[1]), 0);
        step();
        rst = 1'b0;

        // ---------------- reset after 2 of 5 bits on dut 1 ----------------
        vld[1] = 1'b1; bitv[1] = 1'b1;
        step();
        step();
        vld[1] = 1'b0;
        #2;
        rst = 1'b1;
        step();
        rst = 1'b0;
        begin
            logic [4:0] fr;
            fr = 5'b0010_0;
            for (int i = 4; i >= 0; i--) begin
                vld[1] = 1'b1; bitv[1] = fr[i];
                step();
                if (i == 2) check("no_leak_ready", int'(rdy_v[1]), 1);
            end
            vld[1] = 1'b0; bitv[1] = 1'b0;
        end
        check("clean_addr", int'(addr_v[1]), 2);
        check("clean_data", int'(data_v[1]), 0);
        check("clean_ready", int'(rdy_v[1]), 0);
        step();
        check("clean_enable", int'(en_v[1]), 1);
        repeat (4) step();
        check("clean_done_ready", int'(rdy_v[1]), 1);
        check("clean_count", int'(cnt_v[1]), 1);

        // ---------------- frame counter saturation on dut 2 (2-bit) ----------------
        rst = 1'b1; step(); rst = 1'b0;
        check("sat_err_cleared", int'(err_v[2]), 0);
        for (int k = 0; k < 5; k++) begin
            send_frame(2, k, k[0]);
            repeat (5) step();
            check($sformatf("sat_frame%0d_count", k), int'(cnt_v[2]), (k < 3) ? k + 1 : 3);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/frame_config_loader.md
# frame_config_loader

Serial-to-frame configuration loader that sits directly upstream of the I/O tile configuration latches. It deserialises a bit stream into address/data frames and drives the shared `enable`/`address`/`data_in` bus consumed by the tiles' GPIO direction latch memories. Each latch write gets a setup, strobe, hold sequence, so the level-sensitive latches never see address or data change while `enable` is high.

## Interface
- `ADDR_WIDTH`, 4: width of frame address and `address` output.
- `NUM_MEM`, 16: number of addressable latches; legal addresses 0..NUM_MEM-1; must be ≤ 2**ADDR_WIDTH.
- `ENABLE_CYCLES`, 1: `enable` strobe length in clocks; ≥ 1.
- `CNT_WIDTH`, 8: width of `frame_count`.
- `prog_clk`  in  1  configuration clock; all state updates on its rising edge.
- `pReset`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  `cfg_bit` is valid this cycle.
- `cfg_bit`  in  1  serial frame bit, address MSB first, data bit last.
- `cfg_ready`  out  1  loader accepts a bit this cycle.
- `enable`  out  1  latch write strobe to the tile config memories.
- `address`  out  ADDR_WIDTH  latch address; registered.
- `data_in`  out  1  latch data; registered.
- `frame_done`  out  1  one-cycle pulse when a frame's write sequence completes.
- `frame_count`  out  CNT_WIDTH  frames completed, including rejected frames; saturates at all-ones.
- `addr_err`  out  1  sticky flag; set by any frame addressing ≥ NUM_MEM.

## Operation
- Frame is F = ADDR_WIDTH+1 bits. A bit is accepted on an edge where `cfg_valid && cfg_ready`. Bits shift MSB-first into a shift register, with a bit counter 0..F-1.
- States:
  - SHIFT: `cfg_ready`=1. Accepting bit F-1 loads `address` from shreg[ADDR_WIDTH-1:0] and `data_in` from the current bit, clears the bit counter, and goes to SETUP.
  - SETUP: one cycle, `enable`=0, `cfg_ready`=0. Goes to STROBE if address < NUM_MEM. Otherwise goes to HOLD with no strobe and sets `addr_err`.
  - STROBE: `enable`=1 for exactly ENABLE_CYCLES cycles, tracked by a strobe counter, then goes to HOLD.
  - HOLD: one cycle, `enable`=0, `frame_done`=1. `frame_count` increments (saturating) on exit. Goes to SHIFT.
- `address`/`data_in` change only on the frame-load edge. They stay stable from SETUP through HOLD and keep their value in SHIFT until the next frame loads.
- `cfg_valid` while `cfg_ready`=0: the bit is ignored and never buffered. The source must hold it until ready.
- `addr_err` clears only on `pReset`.
- `cfg_valid` low in mid-frame: the partial frame is held indefinitely; no timeout.

## Timing
- Reset values: state SHIFT, bit counter 0, shreg 0, `cfg_ready`=1, `enable`=0, `address`=0, `data_in`=0, `frame_done`=0, `frame_count`=0, `addr_err`=0.
- `pReset` asserted in any state forces `enable`=0 immediately, asynchronously, and discards any partial frame.
- Last bit accepted at edge E:
  - SETUP during cycle E..E+1.
  - `enable` high from edge E+1 to E+1+ENABLE_CYCLES.
  - HOLD for one cycle after that.
  - `cfg_ready` returns high at edge E+ENABLE_CYCLES+2.
- Busy window per frame is ENABLE_CYCLES+2 cycles. Minimum frame period is F+ENABLE_CYCLES+2 cycles.
- Error frame: SETUP to HOLD directly; busy window is 2 cycles; `addr_err` rises at edge E+1.
- All outputs are registered. There is no combinational path from `cfg_valid`/`cfg_bit` to any output.

## Test plan
- Reset check: assert `pReset` with random inputs, then release it. Required: every output equals its reset value; `cfg_ready`=1 on the first cycle.
- Single frame, defaults: send 0101 then 1 with `cfg_valid` continuous. Required: `address`=5, `data_in`=1; `enable` high exactly one cycle, starting one cycle after the last bit; `frame_done` pulses; `frame_count`=1; `cfg_ready` low 3 cycles.
- Back-to-back frames with ENABLE_CYCLES=3: stream frames to addresses 0, 15, 7 with data 1, 0, 1, holding `cfg_valid` high throughout. Required: bits offered while not ready are ignored; three strobes of 3 cycles each; `address`/`data_in` never change while `enable`=1.
- Out-of-range address, NUM_MEM=10: send address 12. Required: no `enable`; `addr_err`=1 at E+1 and sticky; `frame_done` pulses; `frame_count` increments. A following legal frame still strobes normally.
- Reset mid-operation: assert `pReset` during STROBE, and separately after 2 of 5 bits. Required: `enable` drops asynchronously in the same cycle. After release, a full clean frame writes correctly and no stale bits leak into it.
- Counter saturation, CNT_WIDTH=2: send 5 frames. Required: `frame_count` reads 1, 2, 3, 3, 3.
